// File: rtl/rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared definitions for the register-file write-back arbiter: register
// address/data widths, default FIFO depth and starvation limit, stall-bus
// encodings, the FIFO entry layout and the grant encoding.
// ----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W           = 5;
    localparam int DATA_W               = 32;
    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_STARVE_LIMIT = 8;

    // Stall-bus encodings driven onto stallreq_wb.
    localparam logic STALL_NONE = 1'b0;
    localparam logic STALL_HOLD = 1'b1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    // One pending out-of-band result. live=0 means a newer pipe write to
    // the same register has superseded it; it is dropped when it reaches
    // the head.
    typedef struct packed {
        logic      live;
        reg_addr_t waddr;
        reg_data_t wdata;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_AUX  = 2'd2
    } grant_e;

    // r0 is hard-wired zero, so a write to it is not a real GPR write.
    function automatic logic is_gpr_write(input logic we, input reg_addr_t addr);
        return we && (addr != '0);
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundles the WB-stage write port, the out-of-band (aux) result port, the
// register-file write port and the stall request.
//   master : the pipeline/environment side (drives pipe_* and aux_*)
//   slave  : the arbiter (drives aux_ready, rf_*, stallreq_wb)
// ----------------------------------------------------------------------------
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic      pipe_we;
    reg_addr_t pipe_waddr;
    reg_data_t pipe_wdata;

    logic      aux_valid;
    reg_addr_t aux_waddr;
    reg_data_t aux_wdata;
    logic      aux_ready;

    logic      rf_we;
    reg_addr_t rf_waddr;
    reg_data_t rf_wdata;

    logic      stallreq_wb;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output aux_valid, aux_waddr, aux_wdata,
        input  aux_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stallreq_wb
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  aux_valid, aux_waddr, aux_wdata,
        output aux_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stallreq_wb
    );

endinterface

// File: rtl/rf_wb_arbiter_aux_wb_fifo.sv
// ----------------------------------------------------------------------------
// aux_wb_fifo
// Queue of pending out-of-band register writes with a per-entry squash
// compare: when squash_en is high every entry whose waddr matches
// squash_addr has its live bit cleared on the next edge.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push, push_waddr/wdata   enqueue a live entry (caller guarantees !full)
//   pop                      dequeue the head (caller guarantees head_valid)
//   squash_en, squash_addr   kill queued entries targeting squash_addr
//   full                     DEPTH entries held
//   head_valid               at least one entry held
//   head_live/waddr/wdata    contents of the oldest entry
// DEPTH must be a power of two so the pointers wrap by overflow.
// ----------------------------------------------------------------------------
module aux_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  reg_addr_t push_waddr,
    input  reg_data_t push_wdata,
    input  logic      pop,
    input  logic      squash_en,
    input  reg_addr_t squash_addr,
    output logic      full,
    output logic      head_valid,
    output logic      head_live,
    output reg_addr_t head_waddr,
    output reg_data_t head_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t wr_ptr_reg;
    ptr_t rd_ptr_reg;
    cnt_t count_reg;

    // Flat view of all entries so the head can be selected by pointer.
    fifo_entry_t entry_view [DEPTH];

    // Each entry is its own register so the squash compare runs on all of
    // them in parallel every cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        fifo_entry_t entry_reg;
        logic        push_here;
        logic        squash_here;

        assign push_here   = push && (wr_ptr_reg == ptr_t'(gi));
        assign squash_here = squash_en && (entry_reg.waddr == squash_addr);

        // A slot being pushed is free, so push takes priority over squash
        // without losing anything; the caller already filters pushes that
        // collide with the current pipe write.
        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (push_here) begin
                entry_reg <= '{live: 1'b1, waddr: push_waddr, wdata: push_wdata};
            end else if (squash_here) begin
                entry_reg.live <= 1'b0;
            end
        end

        assign entry_view[gi] = entry_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + cnt_t'(1);
                2'b01:   count_reg <= count_reg - cnt_t'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full       = (count_reg == cnt_t'(DEPTH));
    assign head_valid = (count_reg != '0);
    assign head_live  = entry_view[rd_ptr_reg].live;
    assign head_waddr = entry_view[rd_ptr_reg].waddr;
    assign head_wdata = entry_view[rd_ptr_reg].wdata;

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Merges WB-stage GPR writes with out-of-band (divider / long-latency)
// results onto the single register-file write port. The pipe always wins;
// aux results wait in aux_wb_fifo and are written when the pipe is idle.
// A queued result that a newer pipe write supersedes is squashed. If a live
// head waits STARVE_LIMIT cycles, stallreq_wb asks the stall controller to
// open a gap in the pipe.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   pipe_* in, aux_* in / aux_ready out, rf_* out,
//                 stallreq_wb out
// rf_* and stallreq_wb are registered: a grant made in cycle N shows up on
// rf_* in cycle N+1.
// ----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    typedef logic [STARVE_W-1:0] starve_t;

    logic      fifo_full;
    logic      head_valid;
    logic      head_live;
    reg_addr_t head_waddr;
    reg_data_t head_wdata;

    grant_e    grant;
    logic      pipe_grant;
    logic      aux_grant;
    logic      aux_ready;
    logic      fifo_push;
    logic      fifo_pop;

    logic      rf_we_reg,     rf_we_next;
    reg_addr_t rf_waddr_reg,  rf_waddr_next;
    reg_data_t rf_wdata_reg,  rf_wdata_next;
    starve_t   starve_cnt_reg, starve_cnt_next;
    logic      stallreq_reg,  stallreq_next;

    aux_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_waddr  (bus.aux_waddr),
        .push_wdata  (bus.aux_wdata),
        .pop         (fifo_pop),
        .squash_en   (pipe_grant),
        .squash_addr (bus.pipe_waddr),
        .full        (fifo_full),
        .head_valid  (head_valid),
        .head_live   (head_live),
        .head_waddr  (head_waddr),
        .head_wdata  (head_wdata)
    );

    // Ready depends only on occupancy, never on a same-cycle pop, so it
    // has no combinational path from the grant logic.
    assign aux_ready = !fifo_full;

    // Only registered FIFO state feeds the aux grant, so an entry pushed
    // this cycle cannot be granted before the next one.
    always_comb begin
        grant = GRANT_NONE;
        if (is_gpr_write(bus.pipe_we, bus.pipe_waddr)) begin
            grant = GRANT_PIPE;
        end else if (head_valid && head_live) begin
            grant = GRANT_AUX;
        end
    end

    assign pipe_grant = (grant == GRANT_PIPE);
    assign aux_grant  = (grant == GRANT_AUX);

    // r0 results and results already superseded by this cycle's pipe write
    // complete the handshake but are dropped instead of queued.
    assign fifo_push = bus.aux_valid && aux_ready
                    && (bus.aux_waddr != '0)
                    && !(pipe_grant && (bus.aux_waddr == bus.pipe_waddr));

    // Dead heads drain every cycle, even under a pipe write, so they never
    // hold up the live entries behind them.
    assign fifo_pop = head_valid && (!head_live || aux_grant);

    always_comb begin
        rf_we_next    = 1'b0;
        rf_waddr_next = '0;
        rf_wdata_next = '0;
        case (grant)
            GRANT_PIPE: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = bus.pipe_waddr;
                rf_wdata_next = bus.pipe_wdata;
            end
            GRANT_AUX: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = head_waddr;
                rf_wdata_next = head_wdata;
            end
            default: begin
            end
        endcase
    end

    // Starvation counter: counts cycles a live head is passed over and
    // saturates so the stall request stays asserted until the head drains.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!(head_valid && head_live) || aux_grant) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != starve_t'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + starve_t'(1);
        end
        stallreq_next = (starve_cnt_next == starve_t'(STARVE_LIMIT)) ? STALL_HOLD : STALL_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
            starve_cnt_reg <= '0;
            stallreq_reg   <= STALL_NONE;
        end else begin
            rf_we_reg      <= rf_we_next;
            rf_waddr_reg   <= rf_waddr_next;
            rf_wdata_reg   <= rf_wdata_next;
            starve_cnt_reg <= starve_cnt_next;
            stallreq_reg   <= stallreq_next;
        end
    end

    assign bus.aux_ready   = aux_ready;
    assign bus.rf_we       = rf_we_reg;
    assign bus.rf_waddr    = rf_waddr_reg;
    assign bus.rf_wdata    = rf_wdata_reg;
    assign bus.stallreq_wb = stallreq_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed vectors for rf_wb_arbiter (DEPTH=4, STARVE_LIMIT=8). Each vector
// gives one cycle of inputs, the expected aux_ready in that cycle, and the
// expected rf_*/stallreq_wb just after that cycle's clock edge.
// ----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_stall;
    } vec_t;

    logic clk;
    logic rst;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int txn      = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
        input logic av,  input logic [4:0] aa, input logic [31:0] ad,
        input logic e_rdy, input logic e_we, input logic [4:0] e_wa,
        input logic [31:0] e_wd, input logic e_stall);
        vec_t v;
        v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.av = av;   v.aa = aa; v.ad = ad;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, check aux_ready combinationally, clock,
    // then check the registered outputs.
    task automatic apply(input string tag, input vec_t v);
        bus.pipe_we    = v.pwe;
        bus.pipe_waddr = v.pa;
        bus.pipe_wdata = v.pd;
        bus.aux_valid  = v.av;
        bus.aux_waddr  = v.aa;
        bus.aux_wdata  = v.ad;
        #2;
        chk($sformatf("%s[%0d].aux_ready", tag, txn), {31'd0, bus.aux_ready}, {31'd0, v.e_rdy});
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d].rf_we", tag, txn), {31'd0, bus.rf_we}, {31'd0, v.e_we});
        if (v.e_we) begin
            chk($sformatf("%s[%0d].rf_waddr", tag, txn), {27'd0, bus.rf_waddr}, {27'd0, v.e_wa});
            chk($sformatf("%s[%0d].rf_wdata", tag, txn), bus.rf_wdata, v.e_wd);
        end
        chk($sformatf("%s[%0d].stallreq", tag, txn), {31'd0, bus.stallreq_wb}, {31'd0, v.e_stall});
        $display("txn %0d %s: pipe=%b r%0d aux=%b r%0d -> rdy=%b rf_we=%b r%0d %h stall=%b",
                 txn, tag, v.pwe, v.pa, v.av, v.aa, bus.aux_ready,
                 bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stallreq_wb);
        txn++;
    endtask

    vec_t vecs [24];
    vec_t idle;

    initial begin
        idle = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0, 0);

        // aux only: pushed at v0, written after edge of v1
        vecs[0]  = mk(0, 5'd0,  32'h0,    1, 5'd5,  32'h1234, 1, 0, 5'd0,  32'h0,    0);
        vecs[1]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 1, 5'd5,  32'h1234, 0);
        vecs[2]  = idle;
        // plain pipe write
        vecs[3]  = mk(1, 5'd3,  32'h33,   0, 5'd0,  32'h0,    1, 1, 5'd3,  32'h33,   0);
        // squash: r7 queued, pipe r7 overrides, dead head drains silently
        vecs[4]  = mk(1, 5'd1,  32'h11,   1, 5'd7,  32'hAAAA, 1, 1, 5'd1,  32'h11,   0);
        vecs[5]  = mk(1, 5'd7,  32'hBBBB, 0, 5'd0,  32'h0,    1, 1, 5'd7,  32'hBBBB, 0);
        vecs[6]  = idle;
        vecs[7]  = idle;
        // same-cycle aux and pipe to r9: accepted, not queued
        vecs[8]  = mk(1, 5'd9,  32'h99,   1, 5'd9,  32'h77,   1, 1, 5'd9,  32'h99,   0);
        vecs[9]  = idle;
        // r0: pipe r0 loses to live head, aux r0 discarded
        vecs[10] = mk(0, 5'd0,  32'h0,    1, 5'd4,  32'h44,   1, 0, 5'd0,  32'h0,    0);
        vecs[11] = mk(1, 5'd0,  32'hDEAD, 1, 5'd0,  32'h55,   1, 1, 5'd4,  32'h44,   0);
        vecs[12] = idle;
        vecs[13] = mk(1, 5'd0,  32'hBEEF, 0, 5'd0,  32'h0,    1, 0, 5'd0,  32'h0,    0);
        // full: four pushes under pipe writes, fifth refused
        vecs[14] = mk(1, 5'd1,  32'h1,    1, 5'd10, 32'hA0,   1, 1, 5'd1,  32'h1,    0);
        vecs[15] = mk(1, 5'd2,  32'h2,    1, 5'd11, 32'hA1,   1, 1, 5'd2,  32'h2,    0);
        vecs[16] = mk(1, 5'd3,  32'h3,    1, 5'd12, 32'hA2,   1, 1, 5'd3,  32'h3,    0);
        vecs[17] = mk(1, 5'd4,  32'h4,    1, 5'd13, 32'hA3,   1, 1, 5'd4,  32'h4,    0);
        vecs[18] = mk(1, 5'd5,  32'h5,    1, 5'd14, 32'hA4,   0, 1, 5'd5,  32'h5,    0);
        // pipe idle: oldest entry written, ready still 0 this cycle
        vecs[19] = mk(0, 5'd0,  32'h0,    1, 5'd14, 32'hA4,   0, 1, 5'd10, 32'hA0,   0);
        vecs[20] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 1, 5'd11, 32'hA1,   0);
        vecs[21] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 1, 5'd12, 32'hA2,   0);
        vecs[22] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 1, 5'd13, 32'hA3,   0);
        vecs[23] = idle;

        // reset state
        rst            = 1'b1;
        bus.pipe_we    = 1'b0;
        bus.pipe_waddr = '0;
        bus.pipe_wdata = '0;
        bus.aux_valid  = 1'b0;
        bus.aux_waddr  = '0;
        bus.aux_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rf_we",     {31'd0, bus.rf_we},       32'd0);
        chk("reset.rf_waddr",  {27'd0, bus.rf_waddr},    32'd0);
        chk("reset.rf_wdata",  bus.rf_wdata,             32'd0);
        chk("reset.stallreq",  {31'd0, bus.stallreq_wb}, 32'd0);
        chk("reset.aux_ready", {31'd0, bus.aux_ready},   32'd1);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            apply("vec", vecs[i]);
        end

        // starvation: one live entry, pipe busy every cycle
        apply("starve", mk(1, 5'd1, 32'h100, 1, 5'd6, 32'h66, 1, 1, 5'd1, 32'h100, 0));
        for (int k = 1; k <= 8; k++) begin
            apply("starve", mk(1, 5'd2, 32'(k), 0, 5'd0, 32'h0, 1, 1, 5'd2, 32'(k), (k == 8)));
        end
        // pipe write during stall request still wins
        apply("starve", mk(1, 5'd3, 32'h333, 0, 5'd0, 32'h0, 1, 1, 5'd3, 32'h333, 1));
        apply("starve", mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0, 1, 1, 5'd6, 32'h66,  0));
        apply("starve", idle);

        // reset mid-operation: three queued entries are discarded
        apply("rstmid", mk(1, 5'd1, 32'h1, 1, 5'd20, 32'hC0, 1, 1, 5'd1, 32'h1, 0));
        apply("rstmid", mk(1, 5'd1, 32'h2, 1, 5'd21, 32'hC1, 1, 1, 5'd1, 32'h2, 0));
        apply("rstmid", mk(1, 5'd1, 32'h3, 1, 5'd22, 32'hC2, 1, 1, 5'd1, 32'h3, 0));
        rst = 1'b1;
        apply("rstmid", idle);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            apply("rstmid", idle);
        end
        // capacity is back to four after the reset
        for (int k = 0; k < 4; k++) begin
            apply("refill", mk(1, 5'd2, 32'(k), 1, 5'(24 + k), 32'(k), 1, 1, 5'd2, 32'(k), 0));
        end
        apply("refill", mk(1, 5'd2, 32'h9, 1, 5'd30, 32'h9, 0, 1, 5'd2, 32'h9, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, aux FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, cycles a valid FIFO head may wait before a stall request.
REQ-003 clk  in  1  single clock, all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pipe_we  in  1  WB-stage GPR write enable.
REQ-006 pipe_waddr  in  5  WB-stage destination register.
REQ-007 pipe_wdata  in  32  WB-stage write data.
REQ-008 aux_valid  in  1  out-of-band (divider/long-latency) result valid.
REQ-009 aux_waddr  in  5  aux destination register.
REQ-010 aux_wdata  in  32  aux write data.
REQ-011 aux_ready  out  1  aux result accepted this cycle.
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 rf_waddr  out  5  register-file write address.
REQ-014 rf_wdata  out  32  register-file write data.
REQ-015 stallreq_wb  out  1  stall request to the stall controller.

Function
REQ-016 aux_ready SHALL be combinational: 1 when FIFO count < DEPTH, regardless of pops in the same cycle.
REQ-017 Aux handshake SHALL complete when aux_valid && aux_ready; aux_waddr==0 SHALL be accepted and discarded.
REQ-018 Each FIFO entry SHALL hold {live, waddr, wdata}; a push SHALL set live=1.
REQ-019 Grant per cycle: pipe_we && pipe_waddr!=0 -> pipe wins; else live FIFO head -> aux wins; else no write.
REQ-020 rf_we/rf_waddr/rf_wdata SHALL be registered: the grant made in cycle N appears at outputs in cycle N+1; rf_we=0 when nothing granted.
REQ-021 Squash: on a pipe grant to address A, every FIFO entry with waddr==A SHALL get live=0 (pipe value is newer).
REQ-022 An aux input accepted in the same cycle as a pipe grant to the same address SHALL be accepted (aux_ready honoured) but not pushed.
REQ-023 A head with live=0 SHALL be popped without a write in any cycle, including cycles with a pipe grant.
REQ-024 A push into an empty FIFO SHALL NOT be granted in the same cycle (minimum aux latency 2 cycles to rf_we).
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 starve_cnt SHALL increment each cycle a live head exists and is not granted, clear on any aux grant or when FIFO has no live head, and saturate at STARVE_LIMIT.
REQ-027 stallreq_wb SHALL be registered, 1 while starve_cnt==STARVE_LIMIT; it drops the cycle after the starved head is granted.
REQ-028 A pipe write arriving while stallreq_wb=1 SHALL still win (one-cycle stall-bus latency); no pipe write is ever dropped.

Reset
REQ-029 On rst=1: rf_we=0, rf_waddr=0, rf_wdata=0, stallreq_wb=0, FIFO count/pointers=0, all live=0, starve_cnt=0.
REQ-030 rst mid-operation SHALL discard all pending FIFO entries without writes; aux_ready SHALL read 1 in the cycle after rst deasserts.

Structure
REQ-031 Register-address width (5), data width (32), default DEPTH and STARVE_LIMIT SHALL live in the shared defines header alongside the stall-bus constants.
REQ-032 The FIFO with per-entry squash compare SHALL be one sub-module, aux_wb_fifo; grant, output registers and starvation logic stay in the top.

Verification
REQ-033 Aux only: aux r5=0x1234 at cycle 0, pipe idle -> rf_we=1, r5, 0x1234 at cycle 2; aux_ready=1 throughout.
REQ-034 Squash: aux r7=0xAAAA queued, then pipe writes r7=0xBBBB while head blocked -> only 0xBBBB ever written to r7; entry popped silently.
REQ-035 Full: DEPTH=4, 4 aux pushes under continuous pipe writes -> aux_ready=0 on 5th; pipe idle one cycle -> one aux write, aux_ready=1 next cycle.
REQ-036 Starvation: one live entry, pipe_we=1 every cycle -> stallreq_wb rises after 8 blocked cycles; pipe_we=0 next -> aux written, stallreq_wb=0 the cycle after.
REQ-037 Reset: 3 entries queued, rst pulsed one cycle -> no rf_we from those entries, count=0, stallreq_wb=0.
REQ-038 r0: pipe_we=1 to r0 and aux to r0 -> rf_we stays 0; a live FIFO head is granted instead of the r0 pipe write.
